// File: rtl/param_delay_line.sv
// param_delay_line: parametrised delay line with per-stage valids, stall, flush, occupancy and drop statistics.
// Optional even-parity protection per stage is enabled by defining PARAM_DELAY_PARITY_EN.
module param_delay_line #(
   parameter int MSB = 3,
   parameter int LSB = 0,
   parameter int DEPTH = 3,
   parameter logic [MSB-LSB:0] RST_VAL = '0,
   parameter int CW = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         flush,
   input  logic                         d_valid,
   input  logic [MSB:LSB]               d,
   output logic                         q_valid,
   output logic [MSB:LSB]               q,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [CW-1:0]                drop_cnt,
   output logic                         par_err
);
   localparam int OW = $clog2(DEPTH + 1);
   localparam int SW = (CW > 5 ? CW : 5) + 1;
   localparam logic [CW-1:0] DROP_MAX = {CW{1'b1}};

   logic [MSB:LSB]  data_q [DEPTH];
   logic [MSB:LSB]  data_d [DEPTH];
   logic [DEPTH-1:0] v_q, v_d;
   logic [OW-1:0]   occ_q, occ_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [4:0]      pop;
   logic [SW-1:0]   drop_sum;

   // Next stage contents: flush clears, enable shifts, otherwise hold.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) data_d[i] = data_q[i];
      v_d = v_q;
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) data_d[i] = RST_VAL;
         v_d = '0;
      end else if (en) begin
         data_d[0] = d;
         v_d[0] = d_valid;
         for (int i = 1; i < DEPTH; i++) begin
            data_d[i] = data_q[i-1];
            v_d[i] = v_q[i-1];
         end
      end
   end

   // Occupancy tracks entries and exits incrementally instead of recounting valids.
   always_comb begin
      occ_d = flush ? '0 : occ_q + OW'(en & d_valid) - OW'(en & v_q[DEPTH-1]);
   end

   // Flushed valid samples are added to a saturating drop counter.
   always_comb begin
      pop = '0;
      for (int i = 0; i < DEPTH; i++) pop = pop + 5'(v_q[i]);
      drop_sum = SW'(drop_q) + SW'(pop);
      drop_d = !flush ? drop_q : (drop_sum > SW'(DROP_MAX) ? DROP_MAX : drop_sum[CW-1:0]);
   end

   // Stage, occupancy and statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) data_q[i] <= RST_VAL;
         v_q <= '0;
         occ_q <= '0;
         drop_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
         v_q <= v_d;
         occ_q <= occ_d;
         drop_q <= drop_d;
      end
   end

`ifdef PARAM_DELAY_PARITY_EN
   logic [DEPTH-1:0] p_q, p_d;

   // Even parity travels alongside each stage; flush reloads parity of the reset value.
   always_comb begin
      p_d = p_q;
      if (flush) p_d = {DEPTH{^RST_VAL}};
      else if (en) begin
         p_d[0] = ^d;
         for (int i = 1; i < DEPTH; i++) p_d[i] = p_q[i-1];
      end
   end

   // Parity registers.
   always_ff @(posedge clk) begin
      if (rst) p_q <= {DEPTH{^RST_VAL}};
      else p_q <= p_d;
   end

   assign par_err = v_q[DEPTH-1] & ((^data_q[DEPTH-1]) != p_q[DEPTH-1]);
`else
   assign par_err = 1'b0;
`endif

   assign q = data_q[DEPTH-1];
   assign q_valid = v_q[DEPTH-1];
   assign occupancy = occ_q;
   assign drop_cnt = drop_q;
endmodule
